sdram_axi_stream_wr: RTL and testbench
======================================

# sdram_axi_stream_wr

Upstream AXI4 write master for the SDRAM controller. It takes a 32-bit valid/ready data stream, such as from a capture front end or DMA source, and writes it to consecutive SDRAM words starting at a programmed base address. It issues INCR bursts on the controller's AXI4 slave write channels (AW/W/B) and reports completion and error status.

## Interface
Parameters:
- BURST_LEN, 16, maximum beats per burst; power of two, 1..256
- AXI_ID, 4'd0, value driven on awid
- CNT_W, 24, width of the word-count input

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- start_i  in  1  start pulse; sampled only in IDLE
- base_i  in  32  byte base address; bits [1:0] ignored (treated 0)
- words_i  in  CNT_W  number of 32-bit words to write
- busy_o  out  1  high from the cycle after start until done
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky; set on any bresp != OKAY; cleared by start
- s_valid_i  in  1  stream data valid
- s_data_i  in  32  stream data
- s_ready_o  out  1  stream ready
- axi_awvalid_o  out  1  write address valid
- axi_awaddr_o  out  32  burst start address, word aligned
- axi_awid_o  out  4  constant AXI_ID
- axi_awlen_o  out  8  beats-1
- axi_awburst_o  out  2  constant 2'b01 (INCR)
- axi_awready_i  in  1  write address ready
- axi_wvalid_o  out  1  write data valid
- axi_wdata_o  out  32  write data
- axi_wstrb_o  out  4  constant 4'hF
- axi_wlast_o  out  1  last beat of burst
- axi_wready_i  in  1  write data ready
- axi_bvalid_i  in  1  response valid
- axi_bresp_i  in  2  response code
- axi_bid_i  in  4  response ID; ignored
- axi_bready_o  out  1  response ready

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, DONE.
- IDLE -> start_i: latch addr=base_i&~3, rem=words_i, and clear err_o. Go to ADDR if rem!=0, otherwise go to DONE.
- ADDR: axi_awvalid_o=1.
  - Burst beats = min(BURST_LEN, rem, (4096-addr[11:0])>>2). No burst crosses a 4 KB boundary.
  - awlen = beats-1, computed when entering ADDR and held stable while awvalid is high.
  - On awready: go to DATA and load the beat counter.
- DATA: pure passthrough with no buffering.
  - axi_wvalid_o=s_valid_i; s_ready_o=axi_wready_i; axi_wdata_o=s_data_i.
  - axi_wlast_o=1 when beat counter==1.
  - On a W handshake: decrement the beat counter and rem, and add 4 to addr.
  - After the last-beat handshake, go to RESP.
- RESP: axi_bready_o=1.
  - On bvalid: err_o |= (bresp!=0).
  - Go to ADDR if rem!=0, otherwise go to DONE.
- DONE: done_o=1 for one cycle, then go to IDLE.
- start_i outside IDLE is ignored.
- s_ready_o=0 in every state except DATA.
- Address arithmetic is 32-bit and wraps silently at 2^32.
- Reset values: all outputs 0 except the constants awid/awburst/wstrb. Internal state returns to IDLE.
- A reset mid-operation abandons the transfer. The controller must be reset in the same event.

## Timing
- start_i at cycle T gives awvalid and busy_o at T+1.
- AW handshake at T gives first W-beat eligibility at T+1.
- W and the stream are combinationally coupled, adding zero latency.
- The last W handshake at T gives bready at T+1.
- bvalid at T gives the next awvalid at T+1, or done_o at T+1.
- words_i=0: done_o at T+2 after start, with no AXI traffic.
- awaddr, awlen, and awvalid are registered.
- wvalid, wlast, and s_ready are combinational from registered state plus inputs.

## Structure
- Constants (AXI_BURST_INCR, AXI_RESP_OKAY, FSM state encoding) go in the shared sdram_axi_pkg.
- The beats-to-4 KB-boundary min() calculation is a natural sub-module: sdram_axi_burst_calc (combinational; inputs addr, rem; output beats).
- No FIFO. Any buffering is added externally.

## Test plan
- base=0x1000, words=40, BURST_LEN=16, all ready high -> awlen 15, 15, 7 at 0x1000, 0x1040, 0x1080; 40 W beats; one done_o pulse; err_o=0.
- base=0x0FF8, words=8 -> two bursts: awlen=1 at 0x0FF8, then awlen=5 at 0x1000; no 4 KB crossing.
- words=0 -> done_o two cycles after start; awvalid never asserted.
- Random s_valid/wready/awready/bvalid stalls, words=100 -> data written in stream order; wlast on beats 16, 32, …, 96, 100.
- bresp=2'b10 on the second of three bursts -> err_o set and held; the third burst is still issued; a new start clears err_o.
- rst_n_i asserted mid DATA -> all outputs 0 immediately; after release, a new start=0x2000, words=4 completes normally.

Source files
------------

// File: rtl/sdram_axi_pkg.sv
// Shared AXI constants and write-master FSM encoding for the SDRAM AXI front ends.
package sdram_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StResp,
    StDone
  } wr_state_e;

endpackage

// File: rtl/sdram_axi_burst_calc.sv
// Burst sizing: min(BURST_LEN, remaining words, words left before the next 4 KB page).
module sdram_axi_burst_calc #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNT_W     = 24
) (
  input  logic [11:0]      addr_i,
  input  logic [CNT_W-1:0] rem_i,
  output logic [8:0]       beats_o
);

  localparam logic [8:0] MaxBeats = 9'(BURST_LEN);

  logic [12:0] span;
  logic [8:0]  bnd_beats;
  logic [8:0]  rem_beats;

  always_comb begin
    // Bytes left in the page; addr is word aligned so span is a multiple of 4.
    span      = 13'd4096 - {1'b0, addr_i};
    bnd_beats = (span[12:2] > 11'(MaxBeats)) ? MaxBeats : span[10:2];
    rem_beats = (rem_i > CNT_W'(MaxBeats)) ? MaxBeats : rem_i[8:0];
    beats_o   = (rem_beats < bnd_beats) ? rem_beats : bnd_beats;
  end

endmodule

// File: rtl/sdram_axi_stream_wr.sv
// Stream-to-AXI4 write master: writes a valid/ready word stream to consecutive addresses
// using INCR bursts that never cross a 4 KB page.
module sdram_axi_stream_wr
  import sdram_axi_pkg::*;
#(
  parameter int unsigned BURST_LEN = 16,
  parameter logic [3:0]  AXI_ID    = 4'd0,
  parameter int unsigned CNT_W     = 24
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [31:0]      base_i,
  input  logic [CNT_W-1:0] words_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic             s_valid_i,
  input  logic [31:0]      s_data_i,
  output logic             s_ready_o,
  output logic             axi_awvalid_o,
  output logic [31:0]      axi_awaddr_o,
  output logic [3:0]       axi_awid_o,
  output logic [7:0]       axi_awlen_o,
  output logic [1:0]       axi_awburst_o,
  input  logic             axi_awready_i,
  output logic             axi_wvalid_o,
  output logic [31:0]      axi_wdata_o,
  output logic [3:0]       axi_wstrb_o,
  output logic             axi_wlast_o,
  input  logic             axi_wready_i,
  input  logic             axi_bvalid_i,
  input  logic [1:0]       axi_bresp_i,
  input  logic [3:0]       axi_bid_i,
  output logic             axi_bready_o
);

  wr_state_e        state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [8:0]       beat_q, beat_d;
  logic [7:0]       awlen_q, awlen_d;
  logic             err_q, err_d;
  logic             empty_q, empty_d;

  logic [31:0]      base_aligned;
  logic [11:0]      calc_addr;
  logic [CNT_W-1:0] calc_rem;
  logic [8:0]       calc_beats;
  logic             w_hs;
  logic             unused_bid;

  assign unused_bid   = ^axi_bid_i;
  assign base_aligned = base_i & ~32'h3;

  // Size the next burst from the values that will be live when ADDR is entered.
  assign calc_addr = (state_q == StIdle) ? base_aligned[11:0] : addr_q[11:0];
  assign calc_rem  = (state_q == StIdle) ? words_i : rem_q;

  sdram_axi_burst_calc #(
    .BURST_LEN(BURST_LEN),
    .CNT_W    (CNT_W)
  ) u_burst_calc (
    .addr_i (calc_addr),
    .rem_i  (calc_rem),
    .beats_o(calc_beats)
  );

  assign w_hs = (state_q == StData) && s_valid_i && axi_wready_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    awlen_d = awlen_q;
    err_d   = err_q;
    empty_d = empty_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d = base_aligned;
          rem_d  = words_i;
          err_d  = 1'b0;
          if (words_i != '0) begin
            state_d = StAddr;
            awlen_d = 8'(calc_beats - 9'd1);
          end else begin
            state_d = StDone;
            empty_d = 1'b1;
          end
        end
      end
      StAddr: begin
        if (axi_awready_i) begin
          state_d = StData;
          beat_d  = {1'b0, awlen_q} + 9'd1;
        end
      end
      StData: begin
        if (w_hs) begin
          beat_d = beat_q - 9'd1;
          rem_d  = rem_q - CNT_W'(1);
          addr_d = addr_q + 32'd4;
          if (beat_q == 9'd1) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (axi_bvalid_i) begin
          err_d = err_q | (axi_bresp_i != AXI_RESP_OKAY);
          if (rem_q != '0) begin
            state_d = StAddr;
            awlen_d = 8'(calc_beats - 9'd1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // An empty transfer idles here one extra cycle so done lands two cycles after start.
        if (empty_q) begin
          empty_d = 1'b0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      awlen_q <= '0;
      err_q   <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      awlen_q <= awlen_d;
      err_q   <= err_d;
      empty_q <= empty_d;
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone) && !empty_q;
  assign err_o         = err_q;
  assign s_ready_o     = (state_q == StData) && axi_wready_i;
  assign axi_awvalid_o = (state_q == StAddr);
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = AXI_ID;
  assign axi_awlen_o   = awlen_q;
  assign axi_awburst_o = AXI_BURST_INCR;
  assign axi_wvalid_o  = (state_q == StData) && s_valid_i;
  assign axi_wdata_o   = (state_q == StData) ? s_data_i : '0;
  assign axi_wstrb_o   = 4'hF;
  assign axi_wlast_o   = (state_q == StData) && (beat_q == 9'd1);
  assign axi_bready_o  = (state_q == StResp);

endmodule

// File: tb/tb_sdram_axi_stream_wr.sv
// Randomized directed bench for sdram_axi_stream_wr against a page/burst-splitting model.
module tb_sdram_axi_stream_wr;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_i = '0;
  logic [23:0] words_i = '0;
  logic        busy_o, done_o, err_o;
  logic        s_valid_i = 1'b0;
  logic [31:0] s_data_i = '0;
  logic        s_ready_o;
  logic        axi_awvalid_o;
  logic [31:0] axi_awaddr_o;
  logic [3:0]  axi_awid_o;
  logic [7:0]  axi_awlen_o;
  logic [1:0]  axi_awburst_o;
  logic        axi_awready_i = 1'b0;
  logic        axi_wvalid_o;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_wlast_o;
  logic        axi_wready_i = 1'b0;
  logic        axi_bvalid_i = 1'b0;
  logic [1:0]  axi_bresp_i = '0;
  logic [3:0]  axi_bid_i = '0;
  logic        axi_bready_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_len[$];

  always #5 clk_i = ~clk_i;

  sdram_axi_stream_wr #(
    .BURST_LEN(16),
    .AXI_ID   (4'd0),
    .CNT_W    (24)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .base_i       (base_i),
    .words_i      (words_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .s_valid_i    (s_valid_i),
    .s_data_i     (s_data_i),
    .s_ready_o    (s_ready_o),
    .axi_awvalid_o(axi_awvalid_o),
    .axi_awaddr_o (axi_awaddr_o),
    .axi_awid_o   (axi_awid_o),
    .axi_awlen_o  (axi_awlen_o),
    .axi_awburst_o(axi_awburst_o),
    .axi_awready_i(axi_awready_i),
    .axi_wvalid_o (axi_wvalid_o),
    .axi_wdata_o  (axi_wdata_o),
    .axi_wstrb_o  (axi_wstrb_o),
    .axi_wlast_o  (axi_wlast_o),
    .axi_wready_i (axi_wready_i),
    .axi_bvalid_i (axi_bvalid_i),
    .axi_bresp_i  (axi_bresp_i),
    .axi_bid_i    (axi_bid_i),
    .axi_bready_o (axi_bready_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    start_i       = 1'b0;
    s_valid_i     = 1'b0;
    axi_awready_i = 1'b0;
    axi_wready_i  = 1'b0;
    axi_bvalid_i  = 1'b0;
    axi_bresp_i   = 2'b00;
  endtask

  // One transfer: pct is the per-cycle probability (0..100) of each ready/valid input.
  // err_burst selects which burst gets SLVERR (-1 for none); abort_beat>0 returns mid-transfer.
  task automatic run(input logic [31:0] base, input int words, input int pct,
                     input int err_burst, input int abort_beat);
    logic [31:0] ea[$];
    logic [31:0] el[$];
    bit          last_at[$];
    logic [31:0] stream[$];
    logic [31:0] a;
    int          r, room, b, cyc, aw_n, w_n, b_n, wl_n, done_n;
    logic        err_m, exp_err;
    bit          fin;

    // Reference: split into page-bounded bursts of at most 16 words.
    a = base & ~32'h3;
    r = words;
    while (r > 0) begin
      room = int'((32'd4096 - (a & 32'hFFF)) >> 2);
      b = (r < 16) ? r : 16;
      if (room < b) b = room;
      ea.push_back(a);
      el.push_back(32'(b - 1));
      for (int i = 0; i < b; i++) last_at.push_back(i == b - 1);
      a = a + 32'(4 * b);
      r = r - b;
    end
    for (int i = 0; i < words; i++) stream.push_back($urandom);
    exp_err = (err_burst >= 0) && (err_burst < ea.size());
    obs_addr.delete();
    obs_len.delete();
    cyc = 0; aw_n = 0; w_n = 0; b_n = 0; wl_n = 0; done_n = 0;
    err_m = 1'b0;
    fin = 1'b0;

    @(negedge clk_i);
    chk("idle_busy", 32'(busy_o), 32'd0);
    idle_inputs();
    start_i = 1'b1;
    base_i  = base;
    words_i = 24'(words);
    while (!fin) begin
      @(negedge clk_i);
      start_i = 1'b0;
      cyc++;
      axi_awready_i = ($urandom_range(99) < pct);
      axi_wready_i  = ($urandom_range(99) < pct);
      s_valid_i     = (w_n < words) && ($urandom_range(99) < pct);
      s_data_i      = (w_n < words) ? stream[w_n] : $urandom;
      axi_bvalid_i  = (wl_n > b_n) && ($urandom_range(99) < pct);
      axi_bresp_i   = (b_n == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (cyc == 1) begin
        chk("busy_t1", 32'(busy_o), 32'd1);
        chk("awvalid_t1", 32'(axi_awvalid_o), 32'(words != 0));
      end
      chk("err_track", 32'(err_o), 32'(err_m));
      if (aw_n >= ea.size()) chk("aw_extra", 32'(axi_awvalid_o), 32'd0);
      if (axi_awvalid_o && axi_awready_i && aw_n < ea.size()) begin
        chk("awaddr", axi_awaddr_o, ea[aw_n]);
        chk("awlen", 32'(axi_awlen_o), el[aw_n]);
        obs_addr.push_back(axi_awaddr_o);
        obs_len.push_back(32'(axi_awlen_o));
        aw_n++;
      end
      if (axi_wvalid_o && axi_wready_i) begin
        chk("s_ready_hs", 32'(s_ready_o), 32'd1);
        chk("wbeat_in_range", 32'(w_n < words), 32'd1);
        if (w_n < words) begin
          chk("wdata", axi_wdata_o, stream[w_n]);
          chk("wlast", 32'(axi_wlast_o), 32'(last_at[w_n]));
          if (last_at[w_n]) wl_n++;
        end
        w_n++;
      end
      if (axi_bready_o && axi_bvalid_i) begin
        if (axi_bresp_i != 2'b00) err_m = 1'b1;
        b_n++;
      end
      if (done_o) begin
        done_n++;
        if (words == 0) chk("done_latency_empty", 32'(cyc), 32'd2);
        fin = 1'b1;
      end
      if (abort_beat > 0 && w_n >= abort_beat) return;
      if (!fin && cyc > 4000) begin
        chk("done_timeout", 32'(done_n), 32'd1);
        fin = 1'b1;
      end
    end
    idle_inputs();
    @(negedge clk_i);
    #1;
    chk("done_pulse_end", 32'(done_o), 32'd0);
    chk("busy_end", 32'(busy_o), 32'd0);
    chk("aw_count", 32'(aw_n), 32'(ea.size()));
    chk("w_count", 32'(w_n), 32'(words));
    chk("b_count", 32'(b_n), 32'(ea.size()));
    chk("err_final", 32'(err_o), 32'(exp_err));
  endtask

  initial begin
    idle_inputs();
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_awvalid", 32'(axi_awvalid_o), 32'd0);
    chk("rst_wvalid", 32'(axi_wvalid_o), 32'd0);
    chk("rst_bready", 32'(axi_bready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_awid", 32'(axi_awid_o), 32'd0);
    chk("rst_awburst", 32'(axi_awburst_o), 32'd1);
    chk("rst_wstrb", 32'(axi_wstrb_o), 32'hF);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Three bursts, all ready high.
    run(32'h0000_1000, 40, 100, -1, 0);
    chk("t1_nbursts", 32'(obs_addr.size()), 32'd3);
    if (obs_addr.size() == 3) begin
      chk("t1_addr0", obs_addr[0], 32'h1000);
      chk("t1_addr1", obs_addr[1], 32'h1040);
      chk("t1_addr2", obs_addr[2], 32'h1080);
      chk("t1_len0", obs_len[0], 32'd15);
      chk("t1_len1", obs_len[1], 32'd15);
      chk("t1_len2", obs_len[2], 32'd7);
    end

    // Page split just below 4 KB.
    run(32'h0000_0FF8, 8, 100, -1, 0);
    chk("t2_nbursts", 32'(obs_addr.size()), 32'd2);
    if (obs_addr.size() == 2) begin
      chk("t2_addr1", obs_addr[1], 32'h1000);
      chk("t2_len0", obs_len[0], 32'd1);
      chk("t2_len1", obs_len[1], 32'd5);
    end

    run(32'h0000_0400, 0, 100, -1, 0);
    run(32'h0000_4000, 100, 60, -1, 0);
    run(32'h0000_7FFE, 3, 70, -1, 0);
    run(32'hFFFF_FFF8, 4, 80, -1, 0);

    // Error on the middle burst, then a fresh start must clear it.
    run(32'h0000_5000, 40, 65, 1, 0);
    repeat (3) @(negedge clk_i);
    #1;
    chk("err_sticky", 32'(err_o), 32'd1);
    run(32'h0000_6000, 4, 100, -1, 0);

    // Abort mid-burst with reset.
    run(32'h0000_3000, 20, 100, -1, 5);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk("arst_awvalid", 32'(axi_awvalid_o), 32'd0);
    chk("arst_wvalid", 32'(axi_wvalid_o), 32'd0);
    chk("arst_wlast", 32'(axi_wlast_o), 32'd0);
    chk("arst_s_ready", 32'(s_ready_o), 32'd0);
    chk("arst_wdata", axi_wdata_o, 32'd0);
    chk("arst_awaddr", axi_awaddr_o, 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_bready", 32'(axi_bready_o), 32'd0);
    idle_inputs();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    run(32'h0000_2000, 4, 100, -1, 0);
    chk("post_rst_addr0", (obs_addr.size() > 0) ? obs_addr[0] : 32'hDEAD_BEEF, 32'h2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
